// File: rtl/muldiv_pkg.sv
// Shared definitions for the multiply/divide sequencer: control codes,
// FSM state encoding, datapath mode and the control-code decode helper.
package muldiv_pkg;

    localparam logic [3:0] CTL_MULTU = 4'b1100;
    localparam logic [3:0] CTL_DIVU  = 4'b1101;
    localparam logic [3:0] CTL_MULT  = 4'b1110;
    localparam logic [3:0] CTL_DIV   = 4'b1111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PREP = 2'd1,
        RUN  = 2'd2,
        FIX  = 2'd3
    } state_e;

    typedef enum logic {
        MODE_MUL = 1'b0,
        MODE_DIV = 1'b1
    } mode_e;

    function automatic logic is_muldiv(input logic [3:0] control);
        return (control & 4'b1100) == 4'b1100;
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One combinational iteration of the unsigned datapath: shift-add multiply
// (multiplier held in the low half of acc) or restoring shift-subtract divide.
module muldiv_step
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [2*WIDTH-1:0] acc,
    input  logic [WIDTH-1:0]   operand,
    input  mode_e              mode,
    output logic [2*WIDTH-1:0] acc_next
);

    logic [WIDTH:0] add_sum;
    logic [WIDTH:0] rem_shift;
    logic [WIDTH:0] rem_diff;

    always_comb begin
        add_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, operand} : '0);
        rem_shift = acc[2*WIDTH-1:WIDTH-1];
        rem_diff  = rem_shift - {1'b0, operand};
        if (mode == MODE_MUL) begin
            acc_next = {add_sum, acc[WIDTH-1:1]};
        end else if (rem_diff[WIDTH]) begin
            // Borrow out: divisor did not fit, restore and shift in a zero.
            acc_next = {rem_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
        end else begin
            acc_next = {rem_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
        end
    end

endmodule

// File: rtl/muldiv_sequencer.sv
// Multi-cycle MULTU/DIVU/MULT/DIV sequencer (IDLE->PREP->RUN->FIX), one bit per clock.
// Define MULDIV_SIGNED_EN to run 1110/1111 as signed; otherwise they alias 1100/1101.
module muldiv_sequencer
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       control,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    output logic             busy,
    output logic             done,
    output logic             dz,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

`ifdef MULDIV_SIGNED_EN
    localparam logic SIGNED_EN = 1'b1;
`else
    localparam logic SIGNED_EN = 1'b0;
`endif

    localparam int               CNT_W     = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               dz_q, dz_d;
    logic               dz_pend_q, dz_pend_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    mode_e              mode_q, mode_d;
    logic               sgn_q, sgn_d;
    logic               neg_lo_q, neg_lo_d;
    logic               neg_hi_q, neg_hi_d;

    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   op_q, op_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;

    logic [2*WIDTH-1:0] step_acc;
    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;

    function automatic logic [WIDTH-1:0] magnitude(input logic signed [WIDTH-1:0] v,
                                                   input logic use_sign);
        return (use_sign && v < 0) ? WIDTH'(-v) : WIDTH'(v);
    endfunction

    function automatic logic [WIDTH-1:0] apply_sign(input logic [WIDTH-1:0] v,
                                                    input logic neg);
        return neg ? -v : v;
    endfunction

    function automatic logic [2*WIDTH-1:0] apply_sign_wide(input logic [2*WIDTH-1:0] v,
                                                           input logic neg);
        return neg ? -v : v;
    endfunction

    muldiv_step #(
        .WIDTH   (WIDTH)
    ) u_step (
        .acc      (acc_q),
        .operand  (op_q),
        .mode     (mode_q),
        .acc_next (step_acc)
    );

    assign mag_a = magnitude(a_q, sgn_q);
    assign mag_b = magnitude(b_q, sgn_q);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        dz_d      = dz_q;
        dz_pend_d = dz_pend_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        mode_d    = mode_q;
        sgn_d     = sgn_q;
        neg_lo_d  = neg_lo_q;
        neg_hi_d  = neg_hi_q;
        a_d       = a_q;
        b_d       = b_q;
        op_d      = op_q;
        acc_d     = acc_q;

        case (state_q)
            IDLE: begin
                if (start && is_muldiv(control)) begin
                    a_d     = in1;
                    b_d     = in2;
                    mode_d  = control[0] ? MODE_DIV : MODE_MUL;
                    sgn_d   = SIGNED_EN & control[1];
                    busy_d  = 1'b1;
                    state_d = PREP;
                end
            end
            PREP: begin
                cnt_d     = '0;
                dz_pend_d = 1'b0;
                // Quotient/product sign from both operands; remainder follows the dividend.
                neg_lo_d  = sgn_q & (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
                neg_hi_d  = sgn_q & a_q[WIDTH-1];
                if (mode_q == MODE_MUL) begin
                    op_d    = mag_a;
                    acc_d   = {{WIDTH{1'b0}}, mag_b};
                    state_d = RUN;
                end else if (b_q == '0) begin
                    dz_pend_d = 1'b1;
                    state_d   = FIX;
                end else begin
                    op_d    = mag_b;
                    acc_d   = {{WIDTH{1'b0}}, mag_a};
                    state_d = RUN;
                end
            end
            RUN: begin
                acc_d = step_acc;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_ITER) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = IDLE;
                if (dz_pend_q) begin
                    dz_d = 1'b1;
                    hi_d = a_q;
                    lo_d = '1;
                end else if (mode_q == MODE_MUL) begin
                    dz_d         = 1'b0;
                    {hi_d, lo_d} = apply_sign_wide(acc_q, neg_lo_q);
                end else begin
                    dz_d = 1'b0;
                    lo_d = apply_sign(acc_q[WIDTH-1:0], neg_lo_q);
                    hi_d = apply_sign(acc_q[2*WIDTH-1:WIDTH], neg_hi_q);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            dz_q      <= 1'b0;
            dz_pend_q <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            mode_q    <= MODE_MUL;
            sgn_q     <= 1'b0;
            neg_lo_q  <= 1'b0;
            neg_hi_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            dz_q      <= dz_d;
            dz_pend_q <= dz_pend_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            mode_q    <= mode_d;
            sgn_q     <= sgn_d;
            neg_lo_q  <= neg_lo_d;
            neg_hi_q  <= neg_hi_d;
        end
    end

    // Operand and accumulator storage is only meaningful while the FSM is active.
    always_ff @(posedge clk) begin
        a_q   <= a_d;
        b_q   <= b_d;
        op_q  <= op_d;
        acc_q <= acc_d;
    end

    assign busy = busy_q;
    assign done = done_q;
    assign dz   = dz_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: doc/muldiv_sequencer.md
# muldiv_sequencer

Multi-cycle sequencer for the multiply/divide control codes (1100–1111) of the ALU control space. It accepts an operation with a start pulse and iterates one bit per clock through a shift-add multiplier or restoring divider, then writes the HI/LO result pair. It sits beside the ALU in the execute stage, and the pipeline stalls on `busy`.

## Interface
- WIDTH, 32, operand width; HI and LO are WIDTH bits each.
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- control  input  4  1100 MULTU, 1101 DIVU, 1110 MULT, 1111 DIV; other codes are ignored.
- in1  input  WIDTH  multiplicand or dividend.
- in2  input  WIDTH  multiplier or divisor.
- busy  output  1  operation in progress.
- done  output  1  one-cycle pulse when hi/lo have just been updated.
- dz  output  1  divide-by-zero flag for the last operation.
- hi  output  WIDTH  product upper half, or remainder.
- lo  output  WIDTH  product lower half, or quotient.

## Operation
- Reset values: busy=0, done=0, dz=0, hi=0, lo=0, state IDLE, iteration counter 0.
- State machine: IDLE → PREP → RUN → FIX → IDLE.
- IDLE:
  - start=1 with a valid code latches in1, in2 and control, then moves to PREP.
  - An invalid code, or start=0, stays in IDLE with no output change.
- PREP:
  - Signed codes: take absolute values and record the result signs.
  - Clear the accumulator and counter.
  - Divide with in2==0 jumps straight to FIX with the dz path; otherwise go to RUN.
- RUN: exactly WIDTH iterations, one per edge.
  - Multiply: shift-add into a 2·WIDTH accumulator.
  - Divide: restoring shift-subtract.
  - After the last iteration, go to FIX.
- FIX: apply sign correction, register hi/lo/dz, pulse done, return to IDLE.
- Arithmetic:
  - Multiply: {hi,lo} = full 2·WIDTH product, unsigned or two's-complement.
  - Divide: lo = quotient truncated toward zero; hi = remainder carrying the dividend's sign.
  - Signed MIN / −1 gives lo=MIN, hi=0, dz=0.
- Divide by zero: dz=1, hi=in1, lo=all ones, for both signed and unsigned divide.
- dz is cleared on every non-zero-divisor completion.
- hi/lo/dz hold their values between operations; only FIX writes them.
- start while busy=1 is ignored; it is neither queued nor allowed to corrupt operands.
- Changes on in1/in2/control after start is accepted have no effect.
- Reset asserted mid-operation aborts immediately and returns all outputs to their reset values.

## Timing
- Edge 0 is the edge that samples start. busy rises after edge 0.
- Normal operation: done and new hi/lo appear after edge WIDTH+2 (edge 34 for WIDTH=32).
- Divide by zero: done appears after edge 2.
- busy is low in the done cycle.
- A new start may be sampled on the edge that ends the done cycle. Back-to-back throughput is one operation per WIDTH+3 cycles.
- done is never high for two consecutive cycles.

## Configuration
- MULDIV_SIGNED_EN defined:
  - 1110 and 1111 run signed, with PREP sign handling and FIX correction.
- MULDIV_SIGNED_EN undefined:
  - 1110 executes as 1100 and 1111 executes as 1101.
  - Sign logic is removed; latency is unchanged.

## Structure
- Shared package muldiv_pkg holds:
  - Control-code constants CTL_MULTU, CTL_DIVU, CTL_MULT, CTL_DIV.
  - State encoding: IDLE, PREP, RUN, FIX.
  - The is_muldiv(control) helper.
- Sub-module muldiv_step is a combinational single iteration.
  - Inputs: accumulator, operand, mode.
  - Output: the next accumulator.
  - It is instantiated once, and the FSM/counter owns the registers.

## Test plan
- MULTU, in1=FFFFFFFF, in2=FFFFFFFF → after edge 34: hi=FFFFFFFE, lo=00000001, dz=0, single done pulse.
- MULT (macro defined), in1=FFFFFFFD (−3), in2=00000005 → hi=FFFFFFFF, lo=FFFFFFF1.
- DIV (macro defined), in1=FFFFFFF9 (−7), in2=00000002 → lo=FFFFFFFD, hi=FFFFFFFF. Also DIV 80000000/FFFFFFFF → lo=80000000, hi=0.
- DIVU, in1=00000064, in2=0 → done after edge 2 with dz=1, hi=00000064, lo=FFFFFFFF. A following DIVU 100/7 → lo=0000000E, hi=00000002, dz=0.
- Interference checks:
  - Change operands and pulse start at edge 10 of a MULTU 6×7 → result still hi=0, lo=0000002A; no second done.
  - Assert rst at edge 15 → busy, done, hi, lo and dz all read 0 in the next cycle, and the FSM is in IDLE.
- Macro undefined, control=1110, in1=FFFFFFFD, in2=5 → unsigned result hi=00000004, lo=FFFFFFF1.
